// File: rtl/vend_ctrl.sv
// vend_ctrl -- coin-operated vending controller.
// Accepts 5/10/25 cent coins up to a credit ceiling, sells one item at PRICE,
// hands a dispense request to the mechanism and pays back change or refunds.
//
// Handshake summary:
//   coin_valid / select / cancel are single-cycle strobes sampled on the rising
//   edge; there is no back-pressure, so a coin that cannot be taken is answered
//   with a one-cycle coin_reject pulse instead.
//   dispense_req rises the cycle after a successful select and stays high until
//   dispense_ack is sampled high; it drops on the following cycle.
//   change_valid is a one-cycle strobe, change_amt is meaningful only while it
//   is high and reads 0 otherwise.
// Every output is a flop, updated in the single state-machine block below.
// The CHANGE state lasts exactly one cycle; change_valid/change_amt are loaded
// on entry so that the strobe lines up with that cycle, and the credit display
// still shows the amount being paid out until the return to IDLE.

module vend_ctrl #(
    parameter int unsigned PRICE      = 75,
    parameter int unsigned MAX_CREDIT = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid,
    input  logic [1:0] coin_val,
    input  logic       select,
    input  logic       cancel,
    input  logic       dispense_ack,
    output logic       dispense_req,
    output logic       change_valid,
    output logic [7:0] change_amt,
    output logic [7:0] credit,
    output logic       coin_reject,
    output logic       no_funds,
    output logic       busy,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    localparam logic [7:0] PRICE_C = 8'(PRICE);
    localparam logic [8:0] MAX_C   = 9'(MAX_CREDIT);

    state_t     state;
    logic [7:0] coin_cents;
    logic       coin_code_ok;
    logic [8:0] credit_sum;
    logic       coin_fits;
    logic       can_buy;
    logic [7:0] remainder;

    // Decode the inserted coin and work out whether it fits under the ceiling.
    always_comb begin
        coin_cents   = 8'd0;
        coin_code_ok = 1'b1;
        case (coin_val)
            2'b00:   coin_cents = 8'd5;
            2'b01:   coin_cents = 8'd10;
            2'b10:   coin_cents = 8'd25;
            default: coin_code_ok = 1'b0;
        endcase
        credit_sum = {1'b0, credit} + {1'b0, coin_cents};
        coin_fits  = coin_code_ok && (credit_sum <= MAX_C);
    end

    // Purchase arithmetic; credit is never below PRICE while in DISPENSE, the
    // guard only keeps the subtraction from wrapping if that ever broke.
    always_comb begin
        can_buy   = (credit >= PRICE_C);
        remainder = can_buy ? (credit - PRICE_C) : 8'd0;
    end

    // Main controller: state, credit and every registered output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            credit       <= 8'd0;
            dispense_req <= 1'b0;
            change_valid <= 1'b0;
            change_amt   <= 8'd0;
            coin_reject  <= 1'b0;
            no_funds     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // Strobes default low and are raised only for the cycle they apply.
            coin_reject  <= 1'b0;
            no_funds     <= 1'b0;
            change_valid <= 1'b0;
            change_amt   <= 8'd0;

            case (state)
                IDLE, COLLECT: begin
                    if (cancel && (state == COLLECT)) begin
                        // Refund everything; a coin arriving alongside is dropped.
                        state        <= CHANGE;
                        busy         <= 1'b1;
                        change_valid <= 1'b1;
                        change_amt   <= credit;
                        coin_reject  <= coin_valid;
                    end else if (select) begin
                        // IDLE always has zero credit, so select there is short.
                        if ((state == COLLECT) && can_buy) begin
                            state        <= DISPENSE;
                            dispense_req <= 1'b1;
                            busy         <= 1'b1;
                        end else begin
                            no_funds <= 1'b1;
                        end
                        coin_reject <= coin_valid;
                    end else if (coin_valid) begin
                        if (coin_fits) begin
                            credit <= credit_sum[7:0];
                            state  <= COLLECT;
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                end

                DISPENSE: begin
                    // Coins are refused while vending; select/cancel do nothing.
                    coin_reject <= coin_valid;
                    if (dispense_ack) begin
                        dispense_req <= 1'b0;
                        credit       <= remainder;
                        if (remainder == 8'd0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state        <= CHANGE;
                            change_valid <= 1'b1;
                            change_amt   <= remainder;
                        end
                    end
                end

                CHANGE: begin
                    // Payout strobe was issued on entry; close the transaction.
                    coin_reject <= coin_valid;
                    credit      <= 8'd0;
                    state       <= IDLE;
                    busy        <= 1'b0;
                end

                default: begin
                    state        <= IDLE;
                    credit       <= 8'd0;
                    dispense_req <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

    // Expose the state register for checkers and debug.
    always_comb begin
        state_dbg = state;
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl -- directed scenarios plus a randomized run against a
// transaction-level model of the vending rules.

module tb_vend_ctrl;

    localparam int PRICE      = 75;
    localparam int MAX_CREDIT = 200;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_val = 2'b00;
    logic       select = 1'b0;
    logic       cancel = 1'b0;
    logic       dispense_ack = 1'b0;
    logic       dispense_req;
    logic       change_valid;
    logic [7:0] change_amt;
    logic [7:0] credit;
    logic       coin_reject;
    logic       no_funds;
    logic       busy;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    vend_ctrl #(.PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coin_valid   (coin_valid),
        .coin_val     (coin_val),
        .select       (select),
        .cancel       (cancel),
        .dispense_ack (dispense_ack),
        .dispense_req (dispense_req),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .credit       (credit),
        .coin_reject  (coin_reject),
        .no_funds     (no_funds),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];

    // ---------------- driver tasks ----------------
    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one cycle of inputs, clock them in, then return inputs to idle.
    task automatic step(input logic cv, input logic [1:0] cc, input logic s,
                        input logic c, input logic a);
        coin_valid   = cv;
        coin_val     = cc;
        select       = s;
        cancel       = c;
        dispense_ack = a;
        tick();
        coin_valid   = 1'b0;
        coin_val     = 2'b00;
        select       = 1'b0;
        cancel       = 1'b0;
        dispense_ack = 1'b0;
    endtask

    task automatic coin(input logic [1:0] cc);
        step(1'b1, cc, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({dispense_req, change_valid, change_amt, credit, coin_reject, no_funds, busy, state_dbg}
            !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got dreq=%b cv=%b amt=%0d credit=%0d rej=%b nf=%b busy=%b st=%0d, want all 0",
                     dispense_req, change_valid, change_amt, credit, coin_reject, no_funds, busy, state_dbg);
        end
    endtask

    task automatic test_exact_purchase();
        int high_cycles = 0;
        int cv_seen = 0;
        repeat (3) coin(2'b10);
        n_checks++;
        if (credit !== 8'd75) begin
            n_fail++; $display("FAIL exact_credit: got %0d want 75", credit);
        end
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        if (dispense_req) high_cycles++;
        if (change_valid) cv_seen++;
        n_checks++;
        if ({dispense_req, busy} !== 2'b11) begin
            n_fail++; $display("FAIL exact_dispense_start: got dreq=%b busy=%b want 1 1", dispense_req, busy);
        end
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        if (dispense_req) high_cycles++;
        if (change_valid) cv_seen++;
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        if (dispense_req) high_cycles++;
        if (change_valid) cv_seen++;
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        if (dispense_req) high_cycles++;
        if (change_valid) cv_seen++;
        n_checks++;
        if (high_cycles != 3) begin
            n_fail++; $display("FAIL exact_dreq_cycles: got %0d want 3", high_cycles);
        end
        n_checks++;
        if ({credit, busy, dispense_req, change_valid} !== 11'd0) begin
            n_fail++; $display("FAIL exact_after_ack: got credit=%0d busy=%b dreq=%b cv=%b want 0 0 0 0",
                               credit, busy, dispense_req, change_valid);
        end
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        if (change_valid) cv_seen++;
        n_checks++;
        if (cv_seen != 0 || state_dbg !== 2'd0) begin
            n_fail++; $display("FAIL exact_no_change: got cv_count=%0d state=%0d want 0 0", cv_seen, state_dbg);
        end
    endtask

    task automatic test_purchase_with_change();
        repeat (3) coin(2'b10);
        coin(2'b01);
        n_checks++;
        if (credit !== 8'd85) begin
            n_fail++; $display("FAIL change_credit: got %0d want 85", credit);
        end
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({change_valid, change_amt, dispense_req, busy} !== {1'b1, 8'd10, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL change_strobe: got cv=%b amt=%0d dreq=%b busy=%b want 1 10 0 1",
                               change_valid, change_amt, dispense_req, busy);
        end
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({change_valid, change_amt, credit, busy} !== 18'd0) begin
            n_fail++; $display("FAIL change_done: got cv=%b amt=%0d credit=%0d busy=%b want 0 0 0 0",
                               change_valid, change_amt, credit, busy);
        end
    endtask

    task automatic test_no_funds_cancel();
        coin(2'b10);
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({no_funds, credit, dispense_req} !== {1'b1, 8'd25, 1'b0}) begin
            n_fail++; $display("FAIL no_funds_pulse: got nf=%b credit=%0d dreq=%b want 1 25 0",
                               no_funds, credit, dispense_req);
        end
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (no_funds !== 1'b0) begin
            n_fail++; $display("FAIL no_funds_one_cycle: got %b want 0", no_funds);
        end
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({change_valid, change_amt} !== {1'b1, 8'd25}) begin
            n_fail++; $display("FAIL cancel_refund: got cv=%b amt=%0d want 1 25", change_valid, change_amt);
        end
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({credit, state_dbg, change_valid} !== 11'd0) begin
            n_fail++; $display("FAIL cancel_idle: got credit=%0d state=%0d cv=%b want 0 0 0",
                               credit, state_dbg, change_valid);
        end
        // cancel in IDLE does nothing
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({change_valid, busy, state_dbg} !== 4'd0) begin
            n_fail++; $display("FAIL idle_cancel_ignored: got cv=%b busy=%b state=%0d want 0 0 0",
                               change_valid, busy, state_dbg);
        end
    endtask

    task automatic test_ceiling();
        repeat (7) coin(2'b10);
        coin(2'b01);
        coin(2'b00);
        n_checks++;
        if (credit !== 8'd190) begin
            n_fail++; $display("FAIL ceiling_setup: got %0d want 190", credit);
        end
        coin(2'b10);
        n_checks++;
        if ({coin_reject, credit} !== {1'b1, 8'd190}) begin
            n_fail++; $display("FAIL ceiling_overflow: got rej=%b credit=%0d want 1 190", coin_reject, credit);
        end
        coin(2'b11);
        n_checks++;
        if ({coin_reject, credit} !== {1'b1, 8'd190}) begin
            n_fail++; $display("FAIL invalid_coin: got rej=%b credit=%0d want 1 190", coin_reject, credit);
        end
        coin(2'b01);
        n_checks++;
        if ({coin_reject, credit} !== {1'b0, 8'd200}) begin
            n_fail++; $display("FAIL ceiling_exact: got rej=%b credit=%0d want 0 200", coin_reject, credit);
        end
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({change_valid, change_amt} !== {1'b1, 8'd200}) begin
            n_fail++; $display("FAIL ceiling_refund: got cv=%b amt=%0d want 1 200", change_valid, change_amt);
        end
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_priority();
        repeat (4) coin(2'b10);
        step(1'b1, 2'b10, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if ({change_valid, change_amt, coin_reject, dispense_req, no_funds} !== {1'b1, 8'd100, 1'b1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL priority_cancel: got cv=%b amt=%0d rej=%b dreq=%b nf=%b want 1 100 1 0 0",
                               change_valid, change_amt, coin_reject, dispense_req, no_funds);
        end
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({dispense_req, credit, state_dbg} !== 11'd0) begin
            n_fail++; $display("FAIL priority_after: got dreq=%b credit=%0d state=%0d want 0 0 0",
                               dispense_req, credit, state_dbg);
        end
    endtask

    task automatic test_reset_in_dispense();
        int cv_seen = 0;
        repeat (4) coin(2'b10);
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({dispense_req, credit} !== {1'b1, 8'd100}) begin
            n_fail++; $display("FAIL rst_disp_setup: got dreq=%b credit=%0d want 1 100", dispense_req, credit);
        end
        rst_n = 1'b0;
        step(1'b1, 2'b10, 1'b1, 1'b1, 1'b1);
        rst_n = 1'b1;
        n_checks++;
        if ({credit, dispense_req, change_valid, coin_reject, busy, state_dbg} !== 14'd0) begin
            n_fail++; $display("FAIL rst_disp_clear: got credit=%0d dreq=%b cv=%b rej=%b busy=%b state=%0d want all 0",
                               credit, dispense_req, change_valid, coin_reject, busy, state_dbg);
        end
        repeat (5) begin
            step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
            if (change_valid) cv_seen++;
        end
        n_checks++;
        if (cv_seen != 0) begin
            n_fail++; $display("FAIL rst_disp_no_change: got %0d change strobes want 0", cv_seen);
        end
    endtask

    // ---------------- randomized run vs reference model ----------------
    // Model: credit as an integer and a phase (0 = taking coins, 1 = waiting
    // on the dispenser, 2 = paying out). Outputs are derived from those.
    task automatic test_random();
        int m_credit = 0;
        int m_phase  = 0;
        int value;
        logic e_cv, e_rej, e_nf;
        logic [7:0] e_amt;
        logic [19:0] exp_v, got_v;
        logic cv, s, c, a;
        logic [1:0] cc;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cv = ($urandom_range(0, 1) == 1);
            cc = 2'($urandom_range(0, 3));
            s  = ($urandom_range(0, 5) == 0);
            c  = ($urandom_range(0, 11) == 0);
            a  = ($urandom_range(0, 2) == 0);
            value = (cc == 2'd0) ? 5 : (cc == 2'd1) ? 10 : (cc == 2'd2) ? 25 : -1;
            e_cv = 1'b0; e_amt = 8'd0; e_rej = 1'b0; e_nf = 1'b0;
            if (m_phase == 0) begin
                if (c && m_credit > 0) begin
                    e_cv = 1'b1; e_amt = 8'(m_credit); e_rej = cv; m_phase = 2;
                end else if (s) begin
                    if (m_credit >= PRICE) m_phase = 1;
                    else e_nf = 1'b1;
                    e_rej = cv;
                end else if (cv) begin
                    if (value < 0 || m_credit + value > MAX_CREDIT) e_rej = 1'b1;
                    else m_credit = m_credit + value;
                end
            end else if (m_phase == 1) begin
                e_rej = cv;
                if (a) begin
                    m_credit = m_credit - PRICE;
                    if (m_credit == 0) m_phase = 0;
                    else begin
                        m_phase = 2; e_cv = 1'b1; e_amt = 8'(m_credit);
                    end
                end
            end else begin
                e_rej = cv;
                m_credit = 0;
                m_phase = 0;
            end
            if (e_cv) exp_q.push_back(e_amt);
            step(cv, cc, s, c, a);
            exp_v = {m_phase == 1, e_cv, e_amt, 8'(m_credit), e_rej, e_nf, m_phase != 0};
            got_v = {dispense_req, change_valid, change_amt, credit, coin_reject, no_funds, busy};
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL random_cycle %0d: got dreq=%b cv=%b amt=%0d credit=%0d rej=%b nf=%b busy=%b want %b %b %0d %0d %b %b %b",
                         i, got_v[19], got_v[18], got_v[17:10], got_v[9:2], got_v[1], got_v[0], busy,
                         exp_v[19], exp_v[18], exp_v[17:10], exp_v[9:2], exp_v[1], exp_v[0], m_phase != 0);
            end
            if (change_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL random_payout: got unexpected change %0d want none", change_amt);
                end else begin
                    e_amt = exp_q.pop_front();
                    if (change_amt !== e_amt) begin
                        n_fail++; $display("FAIL random_payout: got %0d want %0d", change_amt, e_amt);
                    end
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL random_payout_left: got %0d missing payouts want 0", exp_q.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_exact_purchase();
        test_purchase_with_change();
        test_no_funds_cancel();
        test_ceiling();
        test_priority();
        test_reset_in_dispense();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 SHALL provide parameter PRICE, default 75, item price in cents (1..MAX_CREDIT).
REQ-002 SHALL provide parameter MAX_CREDIT, default 200, credit ceiling in cents (at most 255).
REQ-003 SHALL provide port clk  input  1  system clock, all state updates on rising edge.
REQ-004 SHALL provide port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL provide port coin_valid  input  1  one-cycle coin insertion strobe.
REQ-006 SHALL provide port coin_val  input  2  coin code: 00=5, 01=10, 10=25, 11=invalid.
REQ-007 SHALL provide port select  input  1  one-cycle purchase request.
REQ-008 SHALL provide port cancel  input  1  one-cycle refund request.
REQ-009 SHALL provide port dispense_ack  input  1  dispenser completion acknowledge.
REQ-010 SHALL provide port dispense_req  output  1  dispense request, held until acknowledged.
REQ-011 SHALL provide port change_valid  output  1  one-cycle change/refund strobe.
REQ-012 SHALL provide port change_amt  output  8  change amount in cents, valid with change_valid, else 0.
REQ-013 SHALL provide port credit  output  8  current accumulated credit in cents.
REQ-014 SHALL provide port coin_reject  output  1  one-cycle pulse, coin not accepted.
REQ-015 SHALL provide port no_funds  output  1  one-cycle pulse, select with credit < PRICE.
REQ-016 SHALL provide port busy  output  1  high in DISPENSE and CHANGE states.

Function
REQ-017 SHALL implement FSM states IDLE, COLLECT, DISPENSE, CHANGE; all outputs registered.
REQ-018 SHALL, in IDLE/COLLECT, add an accepted coin to credit so the new value is visible the next cycle; IDLE -> COLLECT on the first accepted coin.
REQ-019 SHALL reject a coin (credit unchanged, coin_reject high next cycle) when coin_val=11, when credit+value > MAX_CREDIT, or when in DISPENSE/CHANGE.
REQ-020 SHALL, in COLLECT, on select with credit >= PRICE, enter DISPENSE and assert dispense_req from the next cycle.
REQ-021 SHALL, in COLLECT, on select with credit < PRICE, stay in COLLECT and pulse no_funds for one cycle; select in IDLE behaves the same.
REQ-022 SHALL, in COLLECT, on cancel, enter CHANGE with refund = full credit; cancel in IDLE is ignored.
REQ-023 SHALL apply same-cycle priority cancel > select > coin; a dropped coin pulses coin_reject.
REQ-024 SHALL hold dispense_req high in DISPENSE until dispense_ack is sampled high, then deassert it the next cycle and set credit = credit - PRICE.
REQ-025 SHALL, after ack, go to IDLE if the remainder is 0, else to CHANGE.
REQ-026 SHALL ignore cancel and select in DISPENSE and CHANGE; dispense_ack outside DISPENSE is ignored.
REQ-027 SHALL, in CHANGE, assert change_valid for exactly one cycle with change_amt = credit, then clear credit to 0 and return to IDLE.
REQ-028 SHALL never let credit exceed MAX_CREDIT or underflow below 0.

Reset
REQ-029 SHALL, on a rising edge with rst_n=0, force IDLE, credit=0, and all outputs 0 regardless of state.
REQ-030 SHALL, on reset mid-DISPENSE or mid-CHANGE, abandon the transaction with no change_valid issued; rst_n has priority over every input.

Verification (PRICE=75, MAX_CREDIT=200)
REQ-031 SHALL cover: coins 25,25,25 then select, ack after 3 cycles -> dispense_req high 3 cycles, credit 75->0, no change_valid, back to IDLE.
REQ-032 SHALL cover: coins 25,25,25,10 then select and ack -> change_valid one cycle with change_amt=10, credit ends 0.
REQ-033 SHALL cover: coin 25 then select -> no_funds pulse, credit stays 25; then cancel -> change_amt=25, IDLE.
REQ-034 SHALL cover: credit 190, insert 25 -> coin_reject, credit 190; insert coin_val=11 -> coin_reject; insert 10 -> credit 200.
REQ-035 SHALL cover: same-cycle cancel+select+coin with credit 100 -> refund 100, coin_reject pulse, no dispense_req.
REQ-036 SHALL cover: rst_n low during DISPENSE with credit 100 -> next cycle credit=0, dispense_req=0, change_valid never asserted.
